// File: rtl/stall_pkg.sv
// Shared types and constants for the AXI stall injector: mode/FSM enums,
// LFSR polynomial, per-channel seed mixing and the LFSR step function.
package stall_pkg;

   typedef enum logic [1:0] {PASS, RANDOM, BURST, BLOCK} stall_mode_e;
   typedef enum logic {ST_OPEN, ST_STALL} burst_st_e;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] SEED_MIX  = 32'h9E37_79B9;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [31:0] ch_seed(input logic [31:0] base, input int ch);
      logic [31:0] s;
      s = base ^ (32'(ch) * SEED_MIX);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   // Galois form, shifting right; taps are applied when the LSB falls out.
   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return {1'b0, x[31:1]} ^ (x[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/axi_stall_injector_if.sv
// Bundle of per-channel valid/ready pairs seen on both sides of the injector.
interface axi_stall_injector_if #(parameter int N_CH = 5) ();
   logic [N_CH-1:0] s_valid;
   logic [N_CH-1:0] s_ready;
   logic [N_CH-1:0] m_valid;
   logic [N_CH-1:0] m_ready;

   // master: upstream source plus downstream sink; slave: the injector itself
   modport master (output s_valid, output m_ready, input s_ready, input m_valid);
   modport slave  (input s_valid, input m_ready, output s_ready, output m_valid);
endinterface

// File: rtl/stall_gen.sv
// One channel of the stall injector: LFSR, gate generator, commit hold and,
// with STALL_STATS_EN defined, saturating stall/transfer counters.
module stall_gen
   import stall_pkg::*;
#(
   parameter int          PROB_W  = 10,
   parameter int          STALL_W = 6,
   parameter logic [31:0] SEED    = 32'h1
) (
   input  logic              clk,
   input  logic              rst,
   input  stall_mode_e       mode,
   input  logic [PROB_W-1:0] prob,
   input  logic              s_valid,
   input  logic              m_ready,
   output logic              s_ready,
   output logic              m_valid
`ifdef STALL_STATS_EN
   ,
   output logic [31:0]       stat_stall,
   output logic [31:0]       stat_xfer
`endif
);

   logic [31:0]        lfsr_q, lfsr_d;
   logic               gate_q, gate_d;
   logic               commit_q, commit_d;
   burst_st_e          st_q, st_d;
   logic [STALL_W-1:0] cnt_q, cnt_d;
   logic [PROB_W-1:0]  draw;
   logic [STALL_W-1:0] len_draw;
   logic               gate_eff;

   assign draw     = lfsr_q[PROB_W-1:0];
   assign len_draw = lfsr_q[PROB_W+STALL_W-1:PROB_W];

   // Outputs are forced low while in reset, whatever the flops still hold.
   assign gate_eff = (gate_q | commit_q) & ~rst;
   assign m_valid  = s_valid & gate_eff;
   assign s_ready  = m_ready & gate_eff;

   always_comb begin
      lfsr_d   = lfsr_next(lfsr_q);
      gate_d   = 1'b0;
      st_d     = ST_OPEN;
      cnt_d    = '0;
      commit_d = m_valid ? ~m_ready : commit_q;
      case (mode)
         PASS:   gate_d = 1'b1;
         RANDOM: gate_d = (draw < prob);
         BURST: begin
            if (st_q == ST_OPEN) begin
               if (draw >= prob) begin
                  st_d  = ST_STALL;
                  cnt_d = len_draw;
               end else begin
                  gate_d = 1'b1;
               end
            end else if (cnt_q == '0) begin
               gate_d = 1'b1;
            end else begin
               st_d  = ST_STALL;
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: gate_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q   <= SEED;
         gate_q   <= 1'b0;
         commit_q <= 1'b0;
         st_q     <= ST_OPEN;
         cnt_q    <= '0;
      end else begin
         lfsr_q   <= lfsr_d;
         gate_q   <= gate_d;
         commit_q <= commit_d;
         st_q     <= st_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef STALL_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      xfer_cnt_d  = xfer_cnt_q;
      if (s_valid && !gate_eff && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (m_valid && m_ready && (xfer_cnt_q != 32'hFFFF_FFFF))
         xfer_cnt_d = xfer_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         xfer_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   assign stat_stall = stall_cnt_q;
   assign stat_xfer  = xfer_cnt_q;
`endif

endmodule

// File: rtl/axi_stall_injector.sv
// Multi-channel AXI valid/ready stall injector; one stall_gen per channel.
// Define STALL_STATS_EN to add the stat_stall/stat_xfer counter ports.
module axi_stall_injector
   import stall_pkg::*;
#(
   parameter int          N_CH    = 5,
   parameter int          PROB_W  = 10,
   parameter int          STALL_W = 6,
   parameter logic [31:0] SEED    = 32'hACE1_2024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_CH-1:0][1:0]        cfg_mode,
   input  logic [N_CH-1:0][PROB_W-1:0] cfg_prob,
   axi_stall_injector_if.slave         bus
`ifdef STALL_STATS_EN
   ,
   output logic [N_CH-1:0][31:0]       stat_stall,
   output logic [N_CH-1:0][31:0]       stat_xfer
`endif
);

   logic [N_CH-1:0] s_ready_w;
   logic [N_CH-1:0] m_valid_w;

   assign bus.s_ready = s_ready_w;
   assign bus.m_valid = m_valid_w;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      stall_gen #(
         .PROB_W  (PROB_W),
         .STALL_W (STALL_W),
         .SEED    (ch_seed(SEED, i))
      ) u_gen (
         .clk        (clk),
         .rst        (rst),
         .mode       (stall_mode_e'(cfg_mode[i])),
         .prob       (cfg_prob[i]),
         .s_valid    (bus.s_valid[i]),
         .m_ready    (bus.m_ready[i]),
         .s_ready    (s_ready_w[i]),
         .m_valid    (m_valid_w[i])
`ifdef STALL_STATS_EN
         ,
         .stat_stall (stat_stall[i]),
         .stat_xfer  (stat_xfer[i])
`endif
      );
   end

endmodule

// File: tb/tb_axi_stall_injector.sv
// Scoreboard bench for axi_stall_injector: stimulus queues expectations,
// a negedge monitor pops and checks them plus AXI hold and burst lengths.
module tb_axi_stall_injector;
   localparam int N  = 5;
   localparam int PW = 10;
   localparam int SW = 3;
   localparam logic [31:0] SEED = 32'hACE1_2024;
   localparam logic [31:0] POLY = 32'h8020_0003;
   localparam logic [31:0] MIX  = 32'h9E37_79B9;
   localparam logic [1:0] M_PASS = 2'd0, M_RANDOM = 2'd1, M_BURST = 2'd2, M_BLOCK = 2'd3;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0][1:0]    cfg_mode;
   logic [N-1:0][PW-1:0] cfg_prob;
   axi_stall_injector_if #(.N_CH(N)) bus ();
`ifdef STALL_STATS_EN
   logic [N-1:0][31:0] stat_stall, stat_xfer;
`endif

   axi_stall_injector #(.N_CH(N), .PROB_W(PW), .STALL_W(SW), .SEED(SEED)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_mode (cfg_mode),
      .cfg_prob (cfg_prob),
      .bus      (bus)
`ifdef STALL_STATS_EN
      ,
      .stat_stall (stat_stall),
      .stat_xfer  (stat_xfer)
`endif
   );

   always #5 clk = ~clk;

   typedef enum int {K_CYC, K_MARK, K_HS, K_SAVE, K_SAME, K_STALLS, K_XFERS, K_RUNS, K_FAIL} kind_e;
   typedef struct {
      kind_e          kind;
      string          name;
      logic [N-1:0]   mask, mv, sr;
      int             ch;
      longint         lo, hi;
   } exp_t;

   exp_t q[$];
   int   total = 0, bad = 0;
   int   hs[N], base[N], saved[N], run[N], nruns[N];
   bit   seen[N];
   logic [N-1:0] pmv = '0, pmr = '0;
   logic prst = 1'b1;
   bit   rl_en = 1'b0;

   task automatic chk(input string nm, input int ch, input longint act, input longint lo, input longint hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s ch%0d: got %0d, expected %0d..%0d", nm, ch, act, lo, hi);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < N; i++)
         if (bus.m_valid[i] && bus.m_ready[i]) hs[i]++;

      if (!rst && !prst)
         for (int i = 0; i < N; i++)
            if (pmv[i] && !pmr[i]) begin
               total++;
               if (bus.m_valid[i] !== 1'b1) begin
                  bad++;
                  $display("FAIL axi_hold ch%0d: m_valid=%b, expected 1", i, bus.m_valid[i]);
               end
            end

      if (bus.s_valid == '1) begin
         total++;
         if (bus.s_ready !== (bus.m_ready & bus.m_valid)) begin
            bad++;
            $display("FAIL ready_eq: s_ready=%b, expected %b", bus.s_ready, bus.m_ready & bus.m_valid);
         end
      end

      for (int i = 0; i < N; i++) begin
         if (!rl_en) begin
            run[i]  = 0;
            seen[i] = 1'b0;
         end else if (!bus.m_valid[i]) begin
            run[i]++;
         end else begin
            if (seen[i] && run[i] > 0) begin
               nruns[i]++;
               chk("burst_run_len", i, run[i], 1, 8);
            end
            seen[i] = 1'b1;
            run[i]  = 0;
         end
      end

      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            K_CYC: begin
               total++;
               if (((bus.m_valid & e.mask) !== (e.mv & e.mask)) ||
                   ((bus.s_ready & e.mask) !== (e.sr & e.mask))) begin
                  bad++;
                  $display("FAIL %s: m_valid=%b s_ready=%b, expected m_valid=%b s_ready=%b (mask %b)",
                           e.name, bus.m_valid, bus.s_ready, e.mv, e.sr, e.mask);
               end
            end
            K_MARK: for (int i = 0; i < N; i++) base[i] = hs[i];
            K_HS:   chk(e.name, e.ch, hs[e.ch] - base[e.ch], e.lo, e.hi);
            K_SAVE: saved[e.ch] = hs[e.ch] - base[e.ch];
            K_SAME: chk(e.name, e.ch, hs[e.ch] - base[e.ch], saved[e.ch], saved[e.ch]);
            K_RUNS: chk(e.name, e.ch, nruns[e.ch], e.lo, e.hi);
`ifdef STALL_STATS_EN
            K_STALLS: chk(e.name, e.ch, longint'(stat_stall[e.ch]), e.lo, e.hi);
            K_XFERS:  chk(e.name, e.ch, longint'(stat_xfer[e.ch]), e.lo, e.hi);
`endif
            K_FAIL: begin
               total++;
               bad++;
               $display("FAIL %s: condition not reached, expected within bound", e.name);
            end
            default: ;
         endcase
      end

      pmv  = bus.m_valid;
      pmr  = bus.m_ready;
      prst = rst;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic r, input logic [N-1:0] sv, input logic [N-1:0] mr);
      @(posedge clk);
      #1;
      rst         = r;
      bus.s_valid = sv;
      bus.m_ready = mr;
   endtask

   task automatic expc(input string nm, input logic [N-1:0] mask, input logic [N-1:0] mv, input logic [N-1:0] sr);
      exp_t e;
      e.kind = K_CYC; e.name = nm; e.mask = mask; e.mv = mv; e.sr = sr;
      e.ch = 0; e.lo = 0; e.hi = 0;
      q.push_back(e);
   endtask

   task automatic push_k(input kind_e k, input string nm, input int ch, input longint lo, input longint hi);
      exp_t e;
      e.kind = k; e.name = nm; e.mask = '0; e.mv = '0; e.sr = '0;
      e.ch = ch; e.lo = lo; e.hi = hi;
      q.push_back(e);
   endtask

   task automatic reset_n(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b1, '1, '1);
         expc("in_reset", '1, '0, '0);
      end
      push_k(K_MARK, "mark", 0, 0, 0);
   endtask

   function automatic logic [31:0] seed_of(input int ch);
      logic [31:0] s;
      s = SEED ^ (32'(ch) * MIX);
      if (s == 32'h0) s = 32'h1;
      return s;
   endfunction

   function automatic logic [31:0] lstep(input logic [31:0] x);
      logic [31:0] y;
      y = x >> 1;
      if (x[0]) y = y ^ POLY;
      return y;
   endfunction

   // Reference run for all channels in RANDOM mode with s_valid=m_ready=1.
   task automatic random_run(input int n, input string nm, input bit stat0);
      logic [31:0]  l [N];
      logic [N-1:0] g, nxt;
      for (int i = 0; i < N; i++) l[i] = seed_of(i);
      g = '0;
      for (int k = 0; k < n; k++) begin
         step(1'b0, '1, '1);
         expc(nm, '1, g, g);
`ifdef STALL_STATS_EN
         if (stat0 && k == 0)
            for (int i = 0; i < N; i++) begin
               push_k(K_STALLS, "stat_stall_cleared", i, 0, 0);
               push_k(K_XFERS,  "stat_xfer_cleared",  i, 0, 0);
            end
`else
         if (stat0 && k == 0) expc("post_reset_idle", '1, '0, '0);
`endif
         for (int i = 0; i < N; i++) begin
            nxt[i] = (l[i][PW-1:0] < cfg_prob[i]);
            l[i]   = lstep(l[i]);
         end
         g = nxt;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r;
      bit          found;
      rst = 1'b1; bus.s_valid = '0; bus.m_ready = '0;
      cfg_mode = {N{M_PASS}};
      cfg_prob = '0;
      for (int i = 0; i < N; i++) begin hs[i] = 0; base[i] = 0; saved[i] = 0; run[i] = 0; nruns[i] = 0; seen[i] = 0; end

      // PASS: first cycle after reset is gated, then 99 handshakes.
      reset_n(3);
      for (int k = 0; k < 100; k++) begin
         step(1'b0, '1, '1);
         expc("pass", '1, (k == 0) ? '0 : '1, (k == 0) ? '0 : '1);
      end
      for (int i = 0; i < N; i++) push_k(K_HS, "pass_hs", i, 99, 99);
`ifdef STALL_STATS_EN
      step(1'b0, '1, '1);
      expc("pass", '1, '1, '1);
      for (int i = 0; i < N; i++) begin
         push_k(K_STALLS, "pass_stat_stall", i, 1, 1);
         push_k(K_XFERS,  "pass_stat_xfer",  i, 99, 99);
      end
`endif
      step(1'b0, 5'b01010, 5'b00110); expc("pass_mix", '1, 5'b01010, 5'b00110);
      step(1'b0, 5'b01000, 5'b01000); expc("pass_mix", '1, 5'b01000, 5'b01000);

      // RANDOM: two identical runs from reset.
      cfg_mode = {N{M_RANDOM}};
      cfg_prob[0] = 10'd0;   cfg_prob[1] = 10'd256; cfg_prob[2] = 10'd256;
      cfg_prob[3] = 10'd1023; cfg_prob[4] = 10'd256;
      reset_n(2);
      random_run(10000, "random", 1'b0);
      push_k(K_HS, "random_p0",    0, 0, 0);
      push_k(K_HS, "random_p256",  1, 2250, 2750);
      push_k(K_HS, "random_p256",  2, 2250, 2750);
      push_k(K_HS, "random_p1023", 3, 9900, 9999);
      push_k(K_HS, "random_p256",  4, 2250, 2750);
      for (int i = 0; i < N; i++) push_k(K_SAVE, "save", i, 0, 0);
      reset_n(2);
      random_run(10000, "random_rerun", 1'b0);
      for (int i = 0; i < N; i++) push_k(K_SAME, "random_rerun_same", i, 0, 0);

      // BLOCK on ch0..3 while their valid is already shown; ch4 stays PASS.
      cfg_mode = {N{M_PASS}};
      reset_n(2);
      step(1'b0, '1, 5'b10000); expc("block_c0", '1, 5'b00000, 5'b00000);
      step(1'b0, '1, 5'b10000);
      for (int i = 0; i < 4; i++) cfg_mode[i] = M_BLOCK;
      expc("block_c1", '1, 5'b11111, 5'b10000);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, '1, 5'b10000); expc("block_hold", '1, 5'b11111, 5'b10000);
      end
      step(1'b0, '1, '1); expc("block_hs", '1, 5'b11111, 5'b11111);
      for (int k = 0; k < 50; k++) begin
         step(1'b0, '1, '1); expc("block_closed", '1, 5'b10000, 5'b10000);
      end
      for (int i = 0; i < 4; i++) push_k(K_HS, "block_hs_cnt", i, 1, 1);
      push_k(K_HS, "block_pass_ch", 4, 56, 56);

      // BURST: run lengths with m_ready=1, then AXI hold with random ready.
      cfg_mode = {N{M_BURST}};
      cfg_prob = {N{10'd1000}};
      reset_n(2);
      rl_en = 1'b1;
      repeat (3000) step(1'b0, '1, '1);
      for (int i = 0; i < N; i++) push_k(K_RUNS, "burst_runs_seen", i, 1, 1_000_000);
      rl_en = 1'b0;
      repeat (2000) begin
         r = $urandom;
         step(1'b0, '1, r[N-1:0]);
      end

      // BURST -> PASS while ch0 is stalled: gate opens one cycle later.
      for (int t = 0; t < 4; t++) begin
         found = 1'b0;
         for (int w = 0; w < 300 && !found; w++) begin
            step(1'b0, '1, '1);
            @(negedge clk);
            #1;
            if (bus.m_valid[0] == 1'b0) found = 1'b1;
         end
         if (!found) begin
            push_k(K_FAIL, "stall_wait", 0, 0, 0);
         end else begin
            cfg_mode[0] = M_PASS;
            step(1'b0, '1, '1);
            expc("burst_to_pass", 5'b00001, 5'b00001, 5'b00001);
            cfg_mode[0] = M_BURST;
            repeat (5) step(1'b0, '1, '1);
         end
      end

      // Reset while committed after 37 handshakes; LFSR restarts from seed.
      cfg_mode = {N{M_PASS}};
      cfg_prob = {N{10'd512}};
      reset_n(2);
      for (int k = 0; k < 38; k++) begin
         step(1'b0, '1, '1);
         expc("pre_rst", '1, (k == 0) ? '0 : '1, (k == 0) ? '0 : '1);
      end
      for (int i = 0; i < N; i++) push_k(K_HS, "pre_rst_hs", i, 37, 37);
      step(1'b0, '1, '0);
      expc("commit_pending", '1, '1, '0);
`ifdef STALL_STATS_EN
      for (int i = 0; i < N; i++) push_k(K_XFERS, "pre_rst_stat_xfer", i, 37, 37);
`endif
      step(1'b1, '1, '0);
      cfg_mode = {N{M_RANDOM}};
      expc("rst_mid_commit", '1, '0, '0);
      random_run(200, "post_rst_random", 1'b1);

      step(1'b0, '0, '0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
